// File: rtl/modn_updown_counter.sv
// ---------------------------------------------------------------------------
// modn_updown_counter
//   Modulo-MODULUS counter with up, down, bounce (triangle) and hold modes,
//   synchronous load with range clamping, and a combinational terminal-count
//   flag for cascading into the enable of a following stage.
//
// Parameters
//   WIDTH       counter width in bits
//   MODULUS     count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset (q=0, dir=0, load_err=0)
//   en          advance one step this cycle
//   load        synchronous load strobe, wins over en
//   load_value  value to load; values >= MODULUS clamp to MODULUS-1
//   mode        00 up, 01 down, 10 bounce, 11 hold
//   q           registered count
//   dir         registered direction, 0 = up, 1 = down
//   tc          combinational terminal count (en & !load & at turn/wrap point)
//   load_err    registered one-cycle pulse after a clamped load
// ---------------------------------------------------------------------------
module modn_updown_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             tc,
    output logic             load_err
);

    // Compare width has one spare bit so MODULUS == 2**WIDTH is representable.
    localparam int unsigned CMP_W = WIDTH + 1;

    localparam logic [WIDTH-1:0] MAX_Q     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] BOUNCE_DN = WIDTH'(MODULUS - 2);
    localparam logic [WIDTH-1:0] ONE_Q     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_Q    = '0;
    localparam logic [CMP_W-1:0] MOD_CMP   = CMP_W'(MODULUS);

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Refuse to elaborate with a modulus the counter cannot represent.
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("modn_updown_counter: MODULUS out of range for WIDTH");
    end

    // Direction doubles as the bounce FSM state.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [WIDTH-1:0] q_q, q_d;
    dir_e             dir_q, dir_d;
    logic             load_err_q, load_err_d;

    logic q_at_max;
    logic q_at_zero;
    logic load_in_range;

    assign q_at_max      = (q_q == MAX_Q);
    assign q_at_zero     = (q_q == ZERO_Q);
    assign load_in_range = ({1'b0, load_value} < MOD_CMP);

    // State register: count, direction and clamp pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q        <= ZERO_Q;
            dir_q      <= DIR_UP;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            dir_q      <= dir_d;
            load_err_q <= load_err_d;
        end
    end

    // Next-state: load beats en; hold mode and en=0 keep q and dir.
    always_comb begin
        q_d        = q_q;
        dir_d      = dir_q;
        load_err_d = 1'b0;

        if (load) begin
            if (load_in_range) begin
                q_d = load_value;
            end else begin
                q_d        = MAX_Q;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            case (mode)
                MODE_UP: begin
                    q_d   = q_at_max ? ZERO_Q : (q_q + ONE_Q);
                    dir_d = DIR_UP;
                end
                MODE_DOWN: begin
                    q_d   = q_at_zero ? MAX_Q : (q_q - ONE_Q);
                    dir_d = DIR_DOWN;
                end
                MODE_BOUNCE: begin
                    // Turn points reflect immediately so each endpoint lasts one step.
                    if (dir_q == DIR_UP) begin
                        if (q_at_max) begin
                            q_d   = BOUNCE_DN;
                            dir_d = DIR_DOWN;
                        end else begin
                            q_d = q_q + ONE_Q;
                        end
                    end else begin
                        if (q_at_zero) begin
                            q_d   = ONE_Q;
                            dir_d = DIR_UP;
                        end else begin
                            q_d = q_q - ONE_Q;
                        end
                    end
                end
                MODE_HOLD: begin
                    q_d   = q_q;
                    dir_d = dir_q;
                end
                default: begin
                    q_d   = q_q;
                    dir_d = dir_q;
                end
            endcase
        end
    end

    // Terminal count: purely from registered state plus en/load/mode.
    always_comb begin
        tc = 1'b0;
        if (en && !load) begin
            case (mode)
                MODE_UP:     tc = q_at_max;
                MODE_DOWN:   tc = q_at_zero;
                MODE_BOUNCE: tc = (dir_q == DIR_UP) ? q_at_max : q_at_zero;
                default:     tc = 1'b0;
            endcase
        end
    end

    assign q        = q_q;
    assign dir      = dir_q;
    assign load_err = load_err_q;

endmodule
